// File: rtl/dsp_core.sv
// Single-issue scalar compute core: runs a latched program of fixed-size slots
// from slot 0 until READY, with LD/ST through a request/ready memory handshake.
module dsp_core #(
  parameter int unsigned REG_W    = 8,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned INSN_W   = 16,
  parameter int unsigned OPC_W    = 4,
  parameter int unsigned INSN_NUM = 16,
  parameter int unsigned REG_NUM  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       init_R0_flag,
  input  logic [REG_W-1:0]           init_R0_data,
  input  logic [INSN_W*INSN_NUM-1:0] insn_data,
  input  logic                       Start,
  output logic                       Ready,
  input  logic [REG_W-1:0]           rd_data_M,
  input  logic                       ready_M,
  output logic [REG_W-1:0]           wr_data_M,
  output logic [ADDR_W-1:0]          addr_M,
  output logic [1:0]                 enable_M
);

  localparam int unsigned PC_W  = $clog2(INSN_NUM);
  localparam int unsigned IDX_W = $clog2(REG_NUM);

  localparam logic [OPC_W-1:0] OP_ADD   = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_SUB   = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_AND   = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_OR    = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_XOR   = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_CMPGE = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_LD    = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_ST    = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_BNZ   = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_READY = OPC_W'(15);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MEM  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic                ready_q, ready_d;
  logic [1:0]          en_q, en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [REG_W-1:0]    wdata_q, wdata_d;
  logic                first_q, first_d;
  logic [REG_W-1:0]    regs_q [REG_NUM];
  logic [REG_W-1:0]    regs_d [REG_NUM];
  logic [INSN_W-1:0]   prog_q [INSN_NUM];
  logic [INSN_W-1:0]   prog_d [INSN_NUM];

  logic [INSN_W-1:0]   insn_c;
  logic [OPC_W-1:0]    opc_c;
  logic [IDX_W-1:0]    a_c, b_c, c_c;
  logic [REG_W-1:0]    ra_c, rb_c, rc_c, alu_c;
  logic                adv_c;
  logic                last_c;

  // Decode of the instruction at PC; fields sit at fixed 4-bit positions.
  always_comb begin
    insn_c = prog_q[pc_q];
    opc_c  = insn_c[INSN_W-1 -: OPC_W];
    a_c    = insn_c[11:8];
    b_c    = insn_c[7:4];
    c_c    = insn_c[3:0];
    ra_c   = regs_q[a_c];
    rb_c   = regs_q[b_c];
    rc_c   = regs_q[c_c];
    last_c = (pc_q == PC_W'(INSN_NUM - 1));
  end

  always_comb begin
    alu_c = '0;
    case (opc_c)
      OP_ADD:   alu_c = REG_W'(rb_c + rc_c);
      OP_SUB:   alu_c = REG_W'(rb_c - rc_c);
      OP_AND:   alu_c = rb_c & rc_c;
      OP_OR:    alu_c = rb_c | rc_c;
      OP_XOR:   alu_c = rb_c ^ rc_c;
      OP_CMPGE: alu_c = REG_W'(rb_c >= rc_c);
      default:  alu_c = '0;
    endcase
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ready_d = ready_q;
    en_d    = en_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    first_d = 1'b0;
    prog_d  = prog_q;
    regs_d  = regs_q;
    adv_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_EXEC;
          pc_d    = '0;
          ready_d = 1'b0;
          for (int i = 0; i < int'(INSN_NUM); i++) begin
            prog_d[i] = insn_data[INSN_W*i +: INSN_W];
          end
          if (init_R0_flag) begin
            regs_d[0] = init_R0_data;
          end
        end
      end

      ST_EXEC: begin
        case (opc_c)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMPGE: begin
            regs_d[a_c] = alu_c;
            adv_c       = 1'b1;
          end
          OP_LD, OP_ST: begin
            state_d = ST_MEM;
            en_d    = (opc_c == OP_LD) ? 2'b01 : 2'b10;
            addr_d  = ADDR_W'(rb_c);
            first_d = 1'b1;
            if (opc_c == OP_ST) begin
              wdata_d = ra_c;
            end
          end
          OP_BNZ: begin
            if (ra_c != '0) begin
              pc_d = PC_W'(b_c);
            end else begin
              adv_c = 1'b1;
            end
          end
          OP_READY: begin
            state_d = ST_IDLE;
            ready_d = 1'b1;
          end
          default: adv_c = 1'b1;
        endcase
      end

      ST_MEM: begin
        // The cycle right after issue never completes, whatever ready_M says.
        if (!first_q && ready_M) begin
          if (en_q[0]) begin
            regs_d[a_c] = rd_data_M;
          end
          en_d    = 2'b00;
          state_d = ST_EXEC;
          adv_c   = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase

    // Stepping past the last slot ends the program like READY.
    if (adv_c) begin
      if (last_c) begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end else begin
        pc_d = PC_W'(pc_q + 1'b1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ready_q <= 1'b1;
      en_q    <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      first_q <= 1'b0;
      for (int i = 0; i < int'(REG_NUM); i++) begin
        regs_q[i] <= '0;
      end
      for (int i = 0; i < int'(INSN_NUM); i++) begin
        prog_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ready_q <= ready_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      first_q <= first_d;
      regs_q  <= regs_d;
      prog_q  <= prog_d;
    end
  end

  assign Ready     = ready_q;
  assign enable_M  = en_q;
  assign addr_M    = addr_q;
  assign wr_data_M = wdata_q;

endmodule

// File: tb/tb_dsp_core.sv
// Scoreboard bench for dsp_core: expected memory transfers and R0 updates are
// queued per program and matched against what the core produces.
module tb_dsp_core;

  localparam int unsigned REG_W    = 8;
  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned INSN_W   = 16;
  localparam int unsigned INSN_NUM = 16;

  typedef struct packed {
    logic [1:0]        en;
    logic [ADDR_W-1:0] addr;
    logic [REG_W-1:0]  data;
  } mem_t;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       init_R0_flag;
  logic [REG_W-1:0]           init_R0_data;
  logic [INSN_W*INSN_NUM-1:0] insn_data;
  logic                       Start;
  logic                       Ready;
  logic [REG_W-1:0]           rd_data_M;
  logic                       ready_M;
  logic [REG_W-1:0]           wr_data_M;
  logic [ADDR_W-1:0]          addr_M;
  logic [1:0]                 enable_M;

  dsp_core dut (
    .clk          (clk),
    .reset        (reset),
    .init_R0_flag (init_R0_flag),
    .init_R0_data (init_R0_data),
    .insn_data    (insn_data),
    .Start        (Start),
    .Ready        (Ready),
    .rd_data_M    (rd_data_M),
    .ready_M      (ready_M),
    .wr_data_M    (wr_data_M),
    .addr_M       (addr_M),
    .enable_M     (enable_M)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [INSN_W-1:0] prog [INSN_NUM];
  mem_t              exp_mem[$];
  mem_t              obs_mem[$];
  logic [REG_W-1:0]  exp_r0[$];
  logic [REG_W-1:0]  obs_r0[$];
  int                cycles;
  int                bus_err;
  bit                timed_out;
  logic              ready_after_start;
  logic [REG_W-1:0]  seed_obs;

  task automatic clear_prog();
    for (int i = 0; i < int'(INSN_NUM); i++) prog[i] = 16'hF000;
    exp_mem.delete();
    exp_r0.delete();
  endtask

  task automatic pack_prog();
    for (int i = 0; i < int'(INSN_NUM); i++) insn_data[INSN_W*i +: INSN_W] = prog[i];
  endtask

  // Launches prog, acts as the memory (ready_M after lat cycles) and records
  // every new transfer and every change of R0 until Ready returns.
  task automatic run_prog(input bit flag, input logic [REG_W-1:0] seed, input int lat,
                          input logic [REG_W-1:0] rdata, input bit disturb);
    logic [REG_W-1:0] prev, r0;
    mem_t cur, held;
    bit in_acc;
    int wait_cnt;
    obs_mem.delete(); obs_r0.delete();
    bus_err = 0; timed_out = 0; cycles = 0; in_acc = 0; wait_cnt = 0; held = '0;
    pack_prog();
    rd_data_M = rdata; init_R0_flag = flag; init_R0_data = seed; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; init_R0_flag = 1'b0;
    ready_after_start = Ready;
    seed_obs = dut.regs_q[0];
    prev = seed_obs;
    while (1) begin
      @(posedge clk); #1;
      cycles++;
      if (disturb && cycles == 1) begin
        Start = 1'b1; init_R0_flag = 1'b1; init_R0_data = 8'hA5;
        for (int i = 0; i < int'(INSN_NUM); i++) insn_data[INSN_W*i +: INSN_W] = 16'hF000;
      end else if (disturb && cycles == 2) begin
        Start = 1'b0; init_R0_flag = 1'b0;
      end
      r0 = dut.regs_q[0];
      if (r0 !== prev) begin obs_r0.push_back(r0); prev = r0; end
      if (enable_M !== 2'b00) begin
        cur.en = enable_M; cur.addr = addr_M; cur.data = wr_data_M;
        if (!in_acc) begin obs_mem.push_back(cur); held = cur; in_acc = 1; wait_cnt = 0; end
        else begin wait_cnt++; if (cur !== held) bus_err++; end
        if (enable_M === 2'b11) bus_err++;
        ready_M = (wait_cnt >= lat);
      end else begin
        in_acc = 0; ready_M = 1'b0;
      end
      if (Ready === 1'b1) break;
      if (cycles >= 200) begin timed_out = 1; break; end
    end
    ready_M = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; Start = 1'b0; init_R0_flag = 1'b0; init_R0_data = '0;
    ready_M = 1'b0; rd_data_M = '0; insn_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (Ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", Ready); end
    checks++; if (enable_M !== 2'b00) begin errors++; $display("FAIL reset_enable got %b want 00", enable_M); end
    checks++; if (addr_M !== '0) begin errors++; $display("FAIL reset_addr got %0d want 0", addr_M); end
    checks++; if (wr_data_M !== '0) begin errors++; $display("FAIL reset_wdata got %0d want 0", wr_data_M); end
    checks++; if (dut.regs_q[0] !== '0) begin errors++; $display("FAIL reset_r0 got %0d want 0", dut.regs_q[0]); end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (Ready !== 1'b1) begin errors++; $display("FAIL idle_ready got %b want 1", Ready); end
  endtask

  task automatic test_store();
    mem_t em, om;
    clear_prog();
    prog[0] = 16'h7000;
    exp_mem.push_back('{2'b10, 8'd0, 8'd0});
    run_prog(1'b0, 8'd0, 3, 8'd0, 1'b0);
    checks++; if (ready_after_start !== 1'b0) begin errors++; $display("FAIL st_busy got %b want 0", ready_after_start); end
    checks++; if (timed_out) begin errors++; $display("FAIL st_timeout got 1 want 0"); end
    checks++; if (cycles != 6) begin errors++; $display("FAIL st_cycles got %0d want 6", cycles); end
    checks++; if (bus_err != 0) begin errors++; $display("FAIL st_bus_stable got %0d want 0", bus_err); end
    checks++; if (obs_mem.size() != exp_mem.size()) begin errors++; $display("FAIL st_count got %0d want %0d", obs_mem.size(), exp_mem.size()); end
    while (exp_mem.size() > 0 && obs_mem.size() > 0) begin
      em = exp_mem.pop_front(); om = obs_mem.pop_front(); checks++;
      if (om !== em) begin errors++; $display("FAIL st_xfer got en=%b addr=%0d data=%0d want en=%b addr=%0d data=%0d", om.en, om.addr, om.data, em.en, em.addr, em.data); end
    end
  endtask

  task automatic test_cmpge_add();
    logic [REG_W-1:0] e, o;
    clear_prog();
    prog[0] = 16'h5000; prog[1] = 16'h0000; prog[2] = 16'h0000;
    exp_r0.push_back(8'd1); exp_r0.push_back(8'd2); exp_r0.push_back(8'd4);
    run_prog(1'b0, 8'd0, 0, 8'd0, 1'b0);
    checks++; if (cycles != 4 || timed_out) begin errors++; $display("FAIL cmpge_cycles got %0d want 4", cycles); end
    checks++; if (obs_r0.size() != exp_r0.size()) begin errors++; $display("FAIL cmpge_r0_count got %0d want %0d", obs_r0.size(), exp_r0.size()); end
    while (exp_r0.size() > 0 && obs_r0.size() > 0) begin
      e = exp_r0.pop_front(); o = obs_r0.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL cmpge_r0 got %0d want %0d", o, e); end
    end
  endtask

  task automatic test_seed_add();
    logic [REG_W-1:0] e, o;
    clear_prog();
    prog[0] = 16'h0000; prog[1] = 16'h0000; prog[2] = 16'h0000;
    exp_r0.push_back(8'd6); exp_r0.push_back(8'd12); exp_r0.push_back(8'd24);
    run_prog(1'b1, 8'd3, 0, 8'd0, 1'b1);
    checks++; if (seed_obs !== 8'd3) begin errors++; $display("FAIL seed_r0 got %0d want 3", seed_obs); end
    checks++; if (cycles != 4 || timed_out) begin errors++; $display("FAIL seed_cycles got %0d want 4", cycles); end
    checks++; if (obs_r0.size() != exp_r0.size()) begin errors++; $display("FAIL seed_r0_count got %0d want %0d", obs_r0.size(), exp_r0.size()); end
    while (exp_r0.size() > 0 && obs_r0.size() > 0) begin
      e = exp_r0.pop_front(); o = obs_r0.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL seed_r0_seq got %0d want %0d", o, e); end
    end
  endtask

  task automatic test_ld_st();
    mem_t em, om;
    logic [REG_W-1:0] e, o;
    clear_prog();
    prog[0] = 16'h6000; prog[1] = 16'h7000;
    exp_mem.push_back('{2'b01, 8'd3, 8'd0});
    exp_mem.push_back('{2'b10, 8'd8, 8'd8});
    exp_r0.push_back(8'd8);
    run_prog(1'b1, 8'd3, 1, 8'd8, 1'b0);
    checks++; if (cycles != 7 || timed_out) begin errors++; $display("FAIL ldst_cycles got %0d want 7", cycles); end
    checks++; if (bus_err != 0) begin errors++; $display("FAIL ldst_bus_stable got %0d want 0", bus_err); end
    checks++; if (obs_mem.size() != exp_mem.size()) begin errors++; $display("FAIL ldst_count got %0d want %0d", obs_mem.size(), exp_mem.size()); end
    while (exp_mem.size() > 0 && obs_mem.size() > 0) begin
      em = exp_mem.pop_front(); om = obs_mem.pop_front(); checks++;
      if (om.en !== em.en || om.addr !== em.addr || (em.en == 2'b10 && om.data !== em.data)) begin
        errors++; $display("FAIL ldst_xfer got en=%b addr=%0d data=%0d want en=%b addr=%0d data=%0d", om.en, om.addr, om.data, em.en, em.addr, em.data);
      end
    end
    while (exp_r0.size() > 0) begin
      e = exp_r0.pop_front(); o = (obs_r0.size() > 0) ? obs_r0.pop_front() : 8'hxx; checks++;
      if (o !== e) begin errors++; $display("FAIL ldst_r0 got %0d want %0d", o, e); end
    end
  endtask

  task automatic test_ld_add();
    logic [REG_W-1:0] e, o;
    clear_prog();
    prog[0] = 16'h6000; prog[1] = 16'h0000; prog[2] = 16'h0000;
    exp_r0.push_back(8'd2); exp_r0.push_back(8'd4); exp_r0.push_back(8'd8);
    run_prog(1'b1, 8'd0, 0, 8'd2, 1'b0);
    checks++; if (seed_obs !== 8'd0) begin errors++; $display("FAIL ldadd_seed got %0d want 0", seed_obs); end
    checks++; if (cycles != 6 || timed_out) begin errors++; $display("FAIL ldadd_cycles got %0d want 6", cycles); end
    checks++; if (obs_r0.size() != exp_r0.size()) begin errors++; $display("FAIL ldadd_r0_count got %0d want %0d", obs_r0.size(), exp_r0.size()); end
    while (exp_r0.size() > 0 && obs_r0.size() > 0) begin
      e = exp_r0.pop_front(); o = obs_r0.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL ldadd_r0 got %0d want %0d", o, e); end
    end
  endtask

  task automatic test_branch();
    clear_prog();
    prog[0] = 16'h8030; prog[1] = 16'h0000; prog[2] = 16'h0000;
    run_prog(1'b1, 8'd1, 0, 8'd0, 1'b0);
    checks++; if (cycles != 2 || timed_out) begin errors++; $display("FAIL bnz_taken_cycles got %0d want 2", cycles); end
    checks++; if (dut.regs_q[0] !== 8'd1) begin errors++; $display("FAIL bnz_taken_r0 got %0d want 1", dut.regs_q[0]); end
    run_prog(1'b1, 8'd0, 0, 8'd0, 1'b0);
    checks++; if (cycles != 4 || timed_out) begin errors++; $display("FAIL bnz_fall_cycles got %0d want 4", cycles); end
    checks++; if (dut.regs_q[0] !== 8'd0) begin errors++; $display("FAIL bnz_fall_r0 got %0d want 0", dut.regs_q[0]); end
  endtask

  task automatic test_alu_mix();
    mem_t em, om;
    clear_prog();
    prog[0] = 16'h0100; prog[1] = 16'h1210; prog[2]  = 16'h3312; prog[3]  = 16'h2412;
    prog[4] = 16'h4512; prog[5] = 16'h5612; prog[6]  = 16'h9000; prog[7]  = 16'h7210;
    prog[8] = 16'h7310; prog[9] = 16'h7530; prog[10] = 16'h7640;
    exp_mem.push_back('{2'b10, 8'd10, 8'd5});
    exp_mem.push_back('{2'b10, 8'd10, 8'd15});
    exp_mem.push_back('{2'b10, 8'd15, 8'd15});
    exp_mem.push_back('{2'b10, 8'd0,  8'd1});
    run_prog(1'b1, 8'd5, 0, 8'd0, 1'b0);
    checks++; if (cycles != 20 || timed_out) begin errors++; $display("FAIL alu_cycles got %0d want 20", cycles); end
    checks++; if (obs_mem.size() != exp_mem.size()) begin errors++; $display("FAIL alu_count got %0d want %0d", obs_mem.size(), exp_mem.size()); end
    while (exp_mem.size() > 0 && obs_mem.size() > 0) begin
      em = exp_mem.pop_front(); om = obs_mem.pop_front(); checks++;
      if (om !== em) begin errors++; $display("FAIL alu_xfer got en=%b addr=%0d data=%0d want en=%b addr=%0d data=%0d", om.en, om.addr, om.data, em.en, em.addr, em.data); end
    end
  endtask

  task automatic test_wrap();
    logic [REG_W-1:0] e, o;
    clear_prog();
    for (int i = 0; i < int'(INSN_NUM); i++) prog[i] = 16'h0000;
    for (int k = 1; k < 8; k++) exp_r0.push_back(8'(1 << k));
    exp_r0.push_back(8'd0);
    run_prog(1'b1, 8'd1, 0, 8'd0, 1'b0);
    checks++; if (cycles != 16 || timed_out) begin errors++; $display("FAIL wrap_cycles got %0d want 16", cycles); end
    checks++; if (obs_r0.size() != exp_r0.size()) begin errors++; $display("FAIL wrap_r0_count got %0d want %0d", obs_r0.size(), exp_r0.size()); end
    while (exp_r0.size() > 0 && obs_r0.size() > 0) begin
      e = exp_r0.pop_front(); o = obs_r0.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL wrap_r0 got %0d want %0d", o, e); end
    end
  endtask

  task automatic test_reset_abort();
    int n;
    clear_prog();
    prog[0] = 16'h7000;
    pack_prog();
    ready_M = 1'b0; init_R0_flag = 1'b1; init_R0_data = 8'd7; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; init_R0_flag = 1'b0;
    n = 0;
    while (enable_M === 2'b00 && n < 10) begin @(posedge clk); #1; n++; end
    checks++; if (enable_M !== 2'b10 || addr_M !== 8'd7) begin errors++; $display("FAIL abort_issue got en=%b addr=%0d want en=10 addr=7", enable_M, addr_M); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (Ready !== 1'b0 || enable_M !== 2'b10) begin errors++; $display("FAIL abort_hold got ready=%b en=%b want ready=0 en=10", Ready, enable_M); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (Ready !== 1'b1 || enable_M !== 2'b00) begin errors++; $display("FAIL abort_state got ready=%b en=%b want ready=1 en=00", Ready, enable_M); end
    checks++; if (addr_M !== '0 || wr_data_M !== '0) begin errors++; $display("FAIL abort_bus got addr=%0d data=%0d want 0 0", addr_M, wr_data_M); end
    checks++; if (dut.regs_q[0] !== '0) begin errors++; $display("FAIL abort_r0 got %0d want 0", dut.regs_q[0]); end
    ready_M = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ready_M = 1'b0;
    checks++; if (enable_M !== 2'b00 || Ready !== 1'b1) begin errors++; $display("FAIL abort_quiet got ready=%b en=%b want ready=1 en=00", Ready, enable_M); end
  endtask

  initial begin
    test_reset();
    test_store();
    test_cmpge_add();
    test_seed_add();
    test_ld_st();
    test_ld_add();
    test_branch();
    test_alu_mix();
    test_wrap();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
